l2_bank_req_arbiter: RTL and testbench

L2_BANK_REQ_ARBITER -- requirements
Module: l2_bank_req_arbiter

---
 rtl/l2_bank_arb_pkg.sv | 13 +
 rtl/l2_bank_req_arbiter_rr_arbiter.sv | 47 ++++
 rtl/l2_bank_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_l2_bank_req_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_bank_arb_pkg.sv
// rtl/l2_bank_arb_pkg.sv - shared state encoding and data/byte-enable widths for the L2 bank arbiter
package l2_bank_arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = 4;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/l2_bank_req_arbiter_rr_arbiter.sv
// rtl/l2_bank_req_arbiter_rr_arbiter.sv - round-robin pick of the first requester at or after a pointer
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;

  // Mask of masters whose index is at or above the pointer
  always_comb begin
    upper_mask = '0;
    for (int j = 0; j < N; j++) begin
      upper_mask[j] = (j >= int'(ptr));
    end
  end

  assign upper_req = req & upper_mask;

  // Lowest requester above the pointer wins; otherwise wrap to the lowest requester overall
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        idx   = IDX_W'(j);
        valid = 1'b1;
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (upper_req[j]) begin
        idx = IDX_W'(j);
      end
    end
    if (valid) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/l2_bank_req_arbiter.sv
// rtl/l2_bank_req_arbiter.sv - L2 bank front end: post-reset clear, round-robin access, read return (L2_BANK_RDATA_REG_EN adds a response register)
module l2_bank_req_arbiter
  import l2_bank_arb_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  parameter int ADDR_WIDTH = 14,
  parameter int BANK_DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             init_ni,
  input  logic [NB_MASTERS-1:0]            req_i,
  output logic [NB_MASTERS-1:0]            gnt_o,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0] add_i,
  input  logic [NB_MASTERS-1:0]            wen_i,
  input  logic [NB_MASTERS*BE_WIDTH-1:0]   be_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0] wdata_i,
  output logic [NB_MASTERS-1:0]            r_valid_o,
  output logic [NB_MASTERS*DATA_WIDTH-1:0] r_rdata_o,
  output logic                             mem_csn_o,
  output logic                             mem_wen_o,
  output logic [BE_WIDTH-1:0]              mem_be_o,
  output logic [ADDR_WIDTH-1:0]            mem_add_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  output logic                             init_done_o
);

  localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  arb_state_t              state_q;
  arb_state_t              state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic                    clr_last;
  logic [IDX_W-1:0]        ptr_q;
  logic [NB_MASTERS-1:0]   arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic                    grant_en;
  logic [NB_MASTERS-1:0]   rd_issue;
  logic [NB_MASTERS-1:0]   rsp_vld_q;
  logic [NB_MASTERS-1:0]   out_vld;
  logic [DATA_WIDTH-1:0]   out_data;

  rr_arbiter #(
    .N     (NB_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign clr_last    = (clr_cnt_q == ADDR_WIDTH'(BANK_DEPTH - 1));
  assign grant_en    = (state_q == RUN) && arb_valid;
  assign gnt_o       = grant_en ? arb_gnt : '0;
  assign init_done_o = (state_q == RUN);
  assign rd_issue    = grant_en ? (arb_gnt & wen_i) : '0;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CHECK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: decide on clearing once, walk the bank, then serve masters forever
  always_comb begin
    state_d = state_q;
    case (state_q)
      CHECK:   state_d = init_ni ? RUN : CLEAR;
      CLEAR:   if (clr_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CHECK;
    endcase
  end

  // Clear address counter, advanced by one word per CLEAR cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_cnt_q <= clr_last ? '0 : clr_cnt_q + 1'b1;
    end
  end

  // Round-robin pointer moves just past the granted master, holds otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (grant_en) begin
      ptr_q <= (arb_idx == IDX_W'(NB_MASTERS - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  // Bank port: zero-fill writes while clearing, else forward the granted master
  always_comb begin
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_be_o    = '0;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    if (state_q == CLEAR) begin
      mem_csn_o   = 1'b0;
      mem_wen_o   = 1'b0;
      mem_be_o    = '1;
      mem_add_o   = clr_cnt_q;
      mem_wdata_o = '0;
    end else if (grant_en) begin
      mem_csn_o   = 1'b0;
      mem_wen_o   = wen_i[arb_idx];
      mem_be_o    = be_i[arb_idx*BE_WIDTH +: BE_WIDTH];
      mem_add_o   = add_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata_o = wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Track which master owns the read the bank is returning this cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_q <= '0;
    end else begin
      rsp_vld_q <= rd_issue;
    end
  end

`ifdef L2_BANK_RDATA_REG_EN
  logic [NB_MASTERS-1:0] rsp2_vld_q;
  logic [DATA_WIDTH-1:0] rsp2_data_q;

  // Extra response stage: capture bank data and owner one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp2_vld_q  <= '0;
      rsp2_data_q <= '0;
    end else begin
      rsp2_vld_q  <= rsp_vld_q;
      rsp2_data_q <= mem_rdata_i;
    end
  end

  assign out_vld  = rsp2_vld_q;
  assign out_data = rsp2_data_q;
`else
  assign out_vld  = rsp_vld_q;
  assign out_data = mem_rdata_i;
`endif

  // Route response data only to the master that owns it; others see zero
  always_comb begin
    r_rdata_o = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      r_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = out_vld[i] ? out_data : '0;
    end
  end

  assign r_valid_o = out_vld;

endmodule

// File: tb/tb_l2_bank_req_arbiter.sv
// tb/tb_l2_bank_req_arbiter.sv - randomized scoreboard bench for l2_bank_req_arbiter
module tb_l2_bank_req_arbiter;

  localparam int NB = 2;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef L2_BANK_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              init_n;
  logic [NB-1:0]     req;
  logic [NB-1:0]     gnt;
  logic [NB*AW-1:0]  add;
  logic [NB-1:0]     wen;
  logic [NB*4-1:0]   be;
  logic [NB*32-1:0]  wdata;
  logic [NB-1:0]     r_valid;
  logic [NB*32-1:0]  r_rdata;
  logic              mem_csn;
  logic              mem_wen;
  logic [3:0]        mem_be;
  logic [AW-1:0]     mem_add;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              init_done;

  typedef struct {
    int          master;
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] bank [DEPTH];
  logic        bank_seeded = 1'b0;
  int          ref_ptr;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  l2_bank_req_arbiter #(
    .NB_MASTERS (NB),
    .ADDR_WIDTH (AW),
    .BANK_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .init_ni     (init_n),
    .req_i       (req),
    .gnt_o       (gnt),
    .add_i       (add),
    .wen_i       (wen),
    .be_i        (be),
    .wdata_i     (wdata),
    .r_valid_o   (r_valid),
    .r_rdata_o   (r_rdata),
    .mem_csn_o   (mem_csn),
    .mem_wen_o   (mem_wen),
    .mem_be_o    (mem_be),
    .mem_add_o   (mem_add),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .init_done_o (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank with one-cycle synchronous read, seeded with junk so the clear is observable
  always @(posedge clk) begin
    if (!bank_seeded) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= $urandom;
      bank_seeded <= 1'b1;
    end else if (!mem_csn) begin
      if (!mem_wen) begin
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) bank[mem_add][8*k +: 8] <= mem_wdata[8*k +: 8];
      end else begin
        mem_rdata <= bank[mem_add];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every r_valid must match the oldest outstanding read
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (r_valid != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 64'(r_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rvalid_owner", 64'(r_valid), 64'(2'b01 << e.master));
          chk("rdata", 64'(r_rdata[e.master*32 +: 32]), 64'(e.data));
          chk("rlatency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        chk("missing_rvalid", 64'(r_valid), 64'(2'b01 << sb[0].master));
        void'(sb.pop_front());
      end
      for (int i = 0; i < NB; i++)
        if (!r_valid[i]) chk("rdata_idle_zero", 64'(r_rdata[i*32 +: 32]), 64'd0);
    end
  end

  // Reset, then walk the init phase; starts and ends at posedge+1
  task automatic init_seq(input logic in_n, input int abort_addr);
    int done_cyc;
    done_cyc = in_n ? 2 : 18;
    rst_n  = 1'b0;
    init_n = in_n;
    req    = '1;
    wen    = '1;
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(r_valid), 64'd0);
    chk("rst_rdata", 64'(r_rdata), 64'd0);
    chk("rst_csn", 64'(mem_csn), 64'd1);
    chk("rst_wen", 64'(mem_wen), 64'd1);
    chk("rst_done", 64'(init_done), 64'd0);
    sb.delete();
    ref_ptr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 1; c <= done_cyc; c++) begin
      if (c >= done_cyc) req = '0;
      @(negedge clk);
      chk("init_done", 64'(init_done), 64'(c >= done_cyc));
      chk("init_gnt", 64'(gnt), 64'd0);
      if (!in_n && c >= 2 && c <= 17) begin
        chk("clr_csn", 64'(mem_csn), 64'd0);
        chk("clr_wen", 64'(mem_wen), 64'd0);
        chk("clr_add", 64'(mem_add), 64'(c - 2));
        chk("clr_be", 64'(mem_be), 64'hF);
        chk("clr_wdata", 64'(mem_wdata), 64'd0);
        if (c - 2 == abort_addr) begin
          rst_n = 1'b0;
          @(posedge clk); #1;
          return;
        end
      end else begin
        chk("init_csn", 64'(mem_csn), 64'd1);
      end
      @(posedge clk); #1;
    end
    if (!in_n) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One RUN cycle: drive requests, check grant and bank port, queue expected read
  task automatic issue(input logic [NB-1:0] r, input logic [NB*AW-1:0] a, input logic [NB-1:0] w,
                       input logic [NB*4-1:0] b, input logic [NB*32-1:0] d);
    int   g;
    int   ad;
    sb_t  e;
    req = r; add = a; wen = w; be = b; wdata = d;
    g = -1;
    for (int k = 0; k < NB; k++) begin
      int j;
      j = (ref_ptr + k) % NB;
      if (g < 0 && r[j]) g = j;
    end
    @(negedge clk);
    chk("gnt", 64'(gnt), (g >= 0) ? 64'(2'b01 << g) : 64'd0);
    chk("mem_csn", 64'(mem_csn), 64'(g < 0));
    if (g >= 0) begin
      ad = int'(a[g*AW +: AW]);
      chk("mem_add", 64'(mem_add), 64'(ad));
      chk("mem_wen", 64'(mem_wen), 64'(w[g]));
      if (w[g]) begin
        e.master = g;
        e.data   = ref_mem[ad];
        e.due    = cyc + LAT;
        sb.push_back(e);
      end else begin
        chk("mem_be", 64'(mem_be), 64'(b[g*4 +: 4]));
        chk("mem_wdata", 64'(mem_wdata), 64'(d[g*32 +: 32]));
        for (int k = 0; k < 4; k++)
          if (b[g*4 + k]) ref_mem[ad][8*k +: 8] = d[g*32 + 8*k +: 8];
      end
    end
    @(posedge clk); #1;
    if (g >= 0) ref_ptr = (g + 1) % NB;
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++)
      issue(NB'($urandom_range(0, 3)), NB*AW'($urandom), NB'($urandom), NB*4'($urandom),
            {$urandom, $urandom});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; init_n = 1'b0; req = '0; add = '0; wen = '0; be = '0; wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_ptr = 0;
    @(posedge clk); #1;

    init_seq(1'b0, -1);

    // master 0 writes DEADBEEF with low half enabled, master 1 reads it back
    issue(2'b01, {4'd0, 4'd5}, 2'b10, 8'h03, {32'h0, 32'hDEADBEEF});
    issue(2'b10, {4'd5, 4'd0}, 2'b11, 8'h00, 64'h0);

    // both masters read continuously: grants alternate, responses back to back
    for (int i = 0; i < 6; i++)
      issue(2'b11, {4'd5, 4'(i)}, 2'b11, 8'h00, 64'h0);

    random_traffic(300);

    // read in flight when reset hits, then warm restart without clearing
    issue(2'b01, {4'd0, 4'd5}, 2'b11, 8'h00, 64'h0);
    init_seq(1'b1, -1);
    for (int i = 0; i < 4; i++) issue(2'b00, '0, '0, '0, '0);

    random_traffic(60);

    // reset in the middle of a clear restarts it from address 0
    init_seq(1'b0, 7);
    init_seq(1'b0, -1);

    random_traffic(100);
    for (int i = 0; i < LAT + 2; i++) issue(2'b00, '0, '0, '0, '0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
